// File: rtl/ex_alu_sequencer.sv
// EX-stage ALU control register plus an optional 32-cycle shift-add MULTU unit.
// Define MULT_EN to build the multiplier; without it MULTU decodes as illegal and hi/lo/stall stay 0.
module ex_alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [1:0]  id_alu_op,
    input  logic [5:0]  id_funct,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic        flush,
    output logic [2:0]  ex_alu_control,
    output logic        ex_valid,
    output logic        ex_illegal,
    output logic        stall,
    output logic        mult_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    logic [2:0] dec_code;
    logic       dec_illegal;
    logic       is_multu;

    always_comb begin
        dec_code    = 3'b010;
        dec_illegal = 1'b0;
        is_multu    = 1'b0;
        case (id_alu_op)
            2'b01: dec_code = 3'b110;
            2'b10: begin
                case (id_funct)
                    6'b100000: dec_code = 3'b010;
                    6'b100010: dec_code = 3'b110;
                    6'b100100: dec_code = 3'b000;
                    6'b100101: dec_code = 3'b001;
                    6'b101010: dec_code = 3'b111;
`ifdef MULT_EN
                    FUNCT_MULTU: is_multu = 1'b1;
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_code = 3'b010;
        endcase
    end

    // Handshake: id_valid has no ready; stall is the only back-pressure and,
    // while high, the ID instruction is held upstream and EX receives bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_alu_control <= 3'b010;
            ex_valid       <= 1'b0;
            ex_illegal     <= 1'b0;
        end else if (stall) begin
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
        end else begin
            ex_alu_control <= dec_code;
            ex_valid       <= id_valid & ~flush & ~is_multu;
            ex_illegal     <= dec_illegal & id_valid & ~flush;
        end
    end

`ifdef MULT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

    mult_state_t state;
    logic [4:0]  count;
    logic [31:0] mcand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic        done_q;
    logic [32:0] step_sum;
    logic        issue;

    // acc_lo starts as the multiplier and is shifted out as the product fills in.
    assign step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
    assign issue    = id_valid & is_multu & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= 5'd0;
            mcand  <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (issue) begin
                        state  <= BUSY;
                        count  <= 5'd0;
                        mcand  <= id_rs_val;
                        acc_hi <= 32'd0;
                        acc_lo <= id_rt_val;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= step_sum[32:1];
                        acc_lo <= {step_sum[0], acc_lo[31:1]};
                        count  <= count + 5'd1;
                        if (count == 5'd31) begin
                            state  <= DONE;
                            hi     <= step_sum[32:1];
                            lo     <= {step_sum[0], acc_lo[31:1]};
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall     = (state == BUSY) & ~rst;
    assign mult_done = done_q & ~rst;
`else
    logic unused_operands;
    assign unused_operands = ^{id_rs_val, id_rt_val};
    assign stall     = 1'b0;
    assign mult_done = 1'b0;
    assign hi        = 32'd0;
    assign lo        = 32'd0;
`endif

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Random + directed bench for ex_alu_sequencer: a reference model pushes expected
// per-cycle outputs into a queue and a monitor pops/compares after each rising edge.
module tb_ex_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        flush;
  logic [2:0]  ex_alu_control;
  logic        ex_valid;
  logic        ex_illegal;
  logic        stall;
  logic        mult_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        valid;
    logic        ill;
    logic        ill_care;
    logic [2:0]  ctrl;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  // reference model state: remaining multiply cycles, pending product, result regs
  int          m_busy = 0;
  bit          m_done = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [2:0]  m_ctrl = 3'b010;

  // clock/reset block
  always #5 clk = ~clk;

  ex_alu_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_alu_op      (id_alu_op),
    .id_funct       (id_funct),
    .id_rs_val      (id_rs_val),
    .id_rt_val      (id_rt_val),
    .flush          (flush),
    .ex_alu_control (ex_alu_control),
    .ex_valid       (ex_valid),
    .ex_illegal     (ex_illegal),
    .stall          (stall),
    .mult_done      (mult_done),
    .hi             (hi),
    .lo             (lo)
  );

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [2:0] code, output logic ill,
                                     output logic multu);
    code  = 3'b010;
    ill   = 1'b0;
    multu = 1'b0;
    if (op == 2'b01) code = 3'b110;
    else if (op == 2'b10) begin
      if (f == 6'b100000) code = 3'b010;
      else if (f == 6'b100010) code = 3'b110;
      else if (f == 6'b100100) code = 3'b000;
      else if (f == 6'b100101) code = 3'b001;
      else if (f == 6'b101010) code = 3'b111;
`ifdef MULT_EN
      else if (f == 6'b011001) multu = 1'b1;
`endif
      else ill = 1'b1;
    end
  endfunction

  // driver: apply one cycle of inputs, predict the state after the next edge
  task automatic drive(input logic r, input logic v, input logic [1:0] op,
                       input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    exp_t e;
    logic [2:0] code;
    logic ill, mu;
    rst = r; id_valid = v; id_alu_op = op; id_funct = f;
    id_rs_val = a; id_rt_val = b; flush = fl;
    ref_decode(op, f, code, ill, mu);
    e = '0;
    if (r) begin
      m_busy = 0; m_done = 0; m_hi = '0; m_lo = '0; m_ctrl = 3'b010;
      e.ill_care = 1'b1;
    end else if (m_busy > 0) begin
      e.ill_care = 1'b1;
      m_done = 0;
      if (fl) m_busy = 0;
      else begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          m_done = 1;
          m_hi = m_prod[63:32];
          m_lo = m_prod[31:0];
        end
      end
    end else begin
      m_done = 0;
      m_ctrl = code;
      e.valid = v & ~fl & ~mu;
      e.ill = ill;
      e.ill_care = v & ~fl;
      if (v && !fl && mu) begin
        m_busy = 32;
        m_prod = {32'd0, a} * {32'd0, b};
      end
    end
    e.ctrl  = m_ctrl;
    e.stall = (m_busy > 0);
    e.done  = m_done;
    e.hi    = m_hi;
    e.lo    = m_lo;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic alu(input logic [1:0] op, input logic [5:0] f);
    drive(1'b0, 1'b1, op, f, $urandom, $urandom, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 6'd0, $urandom, $urandom, 1'b0);
  endtask

  task automatic multu(input logic [31:0] a, input logic [31:0] b, input logic fl);
    drive(1'b0, 1'b1, 2'b10, 6'b011001, a, b, fl);
  endtask

  // valid non-MULTU ALU traffic with no flush
  task automatic filler(input int n);
    logic [5:0] f;
    for (int i = 0; i < n; i++) begin
      f = 6'b100000 + 6'($urandom_range(0, 10));
      drive(1'b0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), f,
            $urandom, $urandom, 1'b0);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", 64'(ex_valid), 64'(e.valid));
        chk("ex_alu_control", 64'(ex_alu_control), 64'(e.ctrl));
        if (e.ill_care) chk("ex_illegal", 64'(ex_illegal), 64'(e.ill));
        chk("stall", 64'(stall), 64'(e.stall));
        chk("mult_done", 64'(mult_done), 64'(e.done));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  initial begin
    logic [5:0] fpool [8];
    logic [5:0] f;
    fpool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
              6'b101010, 6'b011001, 6'b000000, 6'b111111};

    drive(1'b1, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 6'b100010, 32'd0, 32'd0, 1'b0);

    // decode table and illegal funct
    alu(2'b10, 6'b100010);
    alu(2'b10, 6'b000000);
    alu(2'b00, 6'b100100);
    alu(2'b01, 6'b000000);
    alu(2'b11, 6'b101010);
    alu(2'b10, 6'b100000);
    alu(2'b10, 6'b100100);
    alu(2'b10, 6'b100101);
    alu(2'b10, 6'b101010);
    drive(1'b0, 1'b1, 2'b10, 6'b000000, 32'd0, 32'd0, 1'b1);
    idle(2);

    // full multiply, then back-to-back issue in DONE
    multu(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    filler(32);
    multu(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    filler(32);
    idle(2);

    // flush mid-multiply keeps prior hi/lo
    multu(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    filler(9);
    drive(1'b0, 1'b1, 2'b10, 6'b100000, 32'd0, 32'd0, 1'b1);
    idle(3);

    // flush wins over a coincident issue
    multu(32'h0000_0003, 32'h0000_0005, 1'b1);
    idle(3);

    // reset mid-multiply
    multu(32'h0000_0007, 32'h0000_0009, 1'b0);
    filler(4);
    drive(1'b1, 1'b1, 2'b10, 6'b011001, 32'd1, 32'd1, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      f = fpool[$urandom_range(0, 7)];
      if (f == 6'b111111) f = 6'($urandom_range(0, 63));
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), f, $urandom, $urandom,
            $urandom_range(0, 39) == 0);
    end
    idle(2);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
